axis_header_extractor: RTL and testbench

Strips a fixed-length header from the front of each AXI-Stream packet, captures it as a sideband word, and emits the remaining payload realigned and packed to lane 0, with the header held stable on every payload beat. It sits after MAC/framing receive blocks and before protocol parsers. It generalises header tagging with:
- arbitrary header length versus bus width, with built-in packing;
- a mode for header-only packets;
- detection of short packets.

---
 rtl/axis_header_extractor.sv | 167 ++++++++++++++++
 tb/tb_axis_header_extractor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_header_extractor.sv
// axis_header_extractor: strips a fixed-length header from each AXI-Stream packet, emits it as sideband and repacks the payload to lane 0
module axis_header_extractor #(
  parameter int AXIS_BYTES = 4,
  parameter int AXIS_USER_BITS = 1,
  parameter int HEADER_LENGTH_BYTES = 6,
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic                             clk,
  input  logic                             sreset,
  output logic                             axis_i_tready,
  input  logic                             axis_i_tvalid,
  input  logic                             axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]            axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0]          axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]        axis_i_tuser,
  input  logic                             axis_o_tready,
  output logic                             axis_o_tvalid,
  output logic                             axis_o_tlast,
  output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0]          axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]        axis_o_tuser,
  output logic [8*HEADER_LENGTH_BYTES-1:0] axis_o_header,
  output logic                             short_packet,
  output logic                             empty_packet
);
  localparam int B = AXIS_BYTES;
  localparam int H = HEADER_LENGTH_BYTES;
  localparam int O = H % B;
  localparam int DW = 8 * B;
  localparam int CW = $clog2(H + B + 1);
  typedef enum logic [1:0] {HEADER, PAYLOAD, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d, fcnt_q, fcnt_d;
  logic [8*H-1:0] stage_q, stage_d, oh_q, oh_d;
  logic [DW-1:0] res_q, res_d, od_q, od_d, din;
  logic [AXIS_USER_BITS-1:0] ures_q, ures_d, ou_q, ou_d;
  logic [B-1:0] ok_q, ok_d;
  logic ov_q, ov_d, ol_q, ol_d, sp_q, sp_d, ep_q, ep_d;
  logic ld, acc;
  logic [31:0] c, hc;
  function automatic logic [B-1:0] kmask(input logic [31:0] n);
    logic [B-1:0] m;
    for (int i = 0; i < B; i++) m[i] = 32'(i) < n;
    return m;
  endfunction
  assign ld = !ov_q || axis_o_tready;
  assign axis_i_tready = !sreset && state_q != FLUSH && ld;
  assign acc = axis_i_tvalid && axis_i_tready;
  assign axis_o_tvalid = ov_q;
  assign axis_o_tlast = ol_q;
  assign axis_o_tkeep = ok_q;
  assign axis_o_tdata = od_q;
  assign axis_o_tuser = ou_q;
  assign axis_o_header = oh_q;
  assign short_packet = sp_q;
  assign empty_packet = ep_q;
  always_comb begin
    c = '0;
    din = '0;
    for (int i = 0; i < B; i++) begin
      c = c + 32'(axis_i_tkeep[i]);
      din[8*i +: 8] = axis_i_tdata[8*i +: 8] & {8{axis_i_tkeep[i]}};
    end
    hc = 32'(hcnt_q);
    state_d = state_q;
    hcnt_d = hcnt_q;
    fcnt_d = fcnt_q;
    stage_d = stage_q;
    res_d = res_q;
    ures_d = ures_q;
    ov_d = ov_q && !axis_o_tready;
    ol_d = ol_q;
    ok_d = ok_q;
    od_d = od_q;
    ou_d = ou_q;
    oh_d = oh_q;
    sp_d = 1'b0;
    ep_d = 1'b0;
    case (state_q)
      HEADER: if (acc) begin
        for (int j = 0; j < H; j++)
          if (hc == 32'(j - j % B)) stage_d[8*j +: 8] = din[8*(j % B) +: 8];
        hcnt_d = (hc + c < 32'(H)) && !axis_i_tlast ? CW'(hc + c) : '0;
        if (hc + c < 32'(H)) sp_d = axis_i_tlast;
        else if (!axis_i_tlast) begin
          res_d = din >> (8 * O);
          ures_d = axis_i_tuser;
          state_d = PAYLOAD;
        end else if (hc + c == 32'(H)) begin
          ep_d = !EMIT_EMPTY;
          ov_d = EMIT_EMPTY;
          ol_d = 1'b1;
          ok_d = '0;
          od_d = '0;
          ou_d = axis_i_tuser;
        end else begin
          ov_d = 1'b1;
          ol_d = 1'b1;
          ok_d = kmask(c - 32'(O));
          od_d = din >> (8 * O);
          ou_d = axis_i_tuser;
        end
      end
      PAYLOAD: if (acc) begin
        ov_d = 1'b1;
        ou_d = axis_i_tuser;
        if (O == 0) begin
          od_d = din;
          ok_d = axis_i_tkeep;
          ol_d = axis_i_tlast;
          state_d = axis_i_tlast ? HEADER : PAYLOAD;
        end else begin
          od_d = res_q | (din << (8 * (B - O)));
          res_d = din >> (8 * O);
          ures_d = axis_i_tuser;
          ol_d = axis_i_tlast && c <= 32'(O);
          ok_d = ol_d ? kmask(c + 32'(B - O)) : '1;
          fcnt_d = CW'(c - 32'(O));
          state_d = !axis_i_tlast ? PAYLOAD : ol_d ? HEADER : FLUSH;
        end
      end
      FLUSH: if (ld) begin
        ov_d = 1'b1;
        ol_d = 1'b1;
        od_d = res_q;
        ok_d = kmask(32'(fcnt_q));
        ou_d = ures_q;
        state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase
    if (ld && ov_d) oh_d = stage_d;
  end
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= HEADER;
      hcnt_q <= '0;
      fcnt_q <= '0;
      stage_q <= '0;
      res_q <= '0;
      ures_q <= '0;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      ok_q <= '0;
      od_q <= '0;
      ou_q <= '0;
      oh_q <= '0;
      sp_q <= 1'b0;
      ep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      fcnt_q <= fcnt_d;
      stage_q <= stage_d;
      res_q <= res_d;
      ures_q <= ures_d;
      ov_q <= ov_d;
      ol_q <= ol_d;
      ok_q <= ok_d;
      od_q <= od_d;
      ou_q <= ou_d;
      oh_q <= oh_d;
      sp_q <= sp_d;
      ep_q <= ep_d;
    end
  end
endmodule

// File: tb/tb_axis_header_extractor.sv
// tb_axis_header_extractor: directed and randomised checks of header stripping, realignment, flush, short/empty handling and reset
module tb_axis_header_extractor;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l; logic u; logic [63:0] h;} beat_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sreset = 1'b1, iv = 1'b0, il = 1'b0, ordy = 1'b1, rnd_rdy = 1'b0;
  logic [3:0] ikeep = '0;
  logic [31:0] idata = '0;
  logic [0:0] iuser = '0;
  int sel = 0, n_test = 0, n_fail = 0, sp_cnt = 0, ep_cnt = 0, low_cnt = 0;
  logic ir_a[3], ov_a[3], ol_a[3], sp_a[3], ep_a[3];
  logic [3:0] ok_a[3];
  logic [31:0] od_a[3];
  logic [0:0] ou_a[3];
  logic [47:0] h0, h1;
  logic [63:0] h2;
  axis_header_extractor #(.AXIS_BYTES(4), .AXIS_USER_BITS(1), .HEADER_LENGTH_BYTES(6), .EMIT_EMPTY(1)) u0 (
    .clk(clk), .sreset(sreset), .axis_i_tready(ir_a[0]), .axis_i_tvalid(iv && sel == 0), .axis_i_tlast(il),
    .axis_i_tkeep(ikeep), .axis_i_tdata(idata), .axis_i_tuser(iuser), .axis_o_tready(ordy || sel != 0),
    .axis_o_tvalid(ov_a[0]), .axis_o_tlast(ol_a[0]), .axis_o_tkeep(ok_a[0]), .axis_o_tdata(od_a[0]),
    .axis_o_tuser(ou_a[0]), .axis_o_header(h0), .short_packet(sp_a[0]), .empty_packet(ep_a[0]));
  axis_header_extractor #(.AXIS_BYTES(4), .AXIS_USER_BITS(1), .HEADER_LENGTH_BYTES(6), .EMIT_EMPTY(0)) u1 (
    .clk(clk), .sreset(sreset), .axis_i_tready(ir_a[1]), .axis_i_tvalid(iv && sel == 1), .axis_i_tlast(il),
    .axis_i_tkeep(ikeep), .axis_i_tdata(idata), .axis_i_tuser(iuser), .axis_o_tready(ordy || sel != 1),
    .axis_o_tvalid(ov_a[1]), .axis_o_tlast(ol_a[1]), .axis_o_tkeep(ok_a[1]), .axis_o_tdata(od_a[1]),
    .axis_o_tuser(ou_a[1]), .axis_o_header(h1), .short_packet(sp_a[1]), .empty_packet(ep_a[1]));
  axis_header_extractor #(.AXIS_BYTES(4), .AXIS_USER_BITS(1), .HEADER_LENGTH_BYTES(8), .EMIT_EMPTY(1)) u2 (
    .clk(clk), .sreset(sreset), .axis_i_tready(ir_a[2]), .axis_i_tvalid(iv && sel == 2), .axis_i_tlast(il),
    .axis_i_tkeep(ikeep), .axis_i_tdata(idata), .axis_i_tuser(iuser), .axis_o_tready(ordy || sel != 2),
    .axis_o_tvalid(ov_a[2]), .axis_o_tlast(ol_a[2]), .axis_o_tkeep(ok_a[2]), .axis_o_tdata(od_a[2]),
    .axis_o_tuser(ou_a[2]), .axis_o_header(h2), .short_packet(sp_a[2]), .empty_packet(ep_a[2]));
  logic ir, ov, ol, ou, sp, ep;
  logic [3:0] ok;
  logic [31:0] od;
  logic [63:0] oh;
  beat_t cur, snap;
  beat_t obs[$], exp[$];
  logic stall_q = 1'b0;
  assign ir = ir_a[sel];
  assign ov = ov_a[sel];
  assign ol = ol_a[sel];
  assign ou = ou_a[sel][0];
  assign sp = sp_a[sel];
  assign ep = ep_a[sel];
  assign ok = ok_a[sel];
  assign od = od_a[sel];
  assign oh = sel == 0 ? {16'h0, h0} : sel == 1 ? {16'h0, h1} : h2;
  assign cur = {od, ok, ol, ou, oh};
  initial forever begin
    @(posedge clk);
    #1;
    ordy = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (sreset) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        n_test++;
        if (cur !== snap) begin n_fail++; $display("FAIL stall_hold: got %h, required %h", cur, snap); end
      end
      stall_q = ov && !ordy;
      snap = cur;
      if (ov && ordy) obs.push_back(cur);
      sp_cnt += int'(sp);
      ep_cnt += int'(ep);
      if (!ir) low_cnt++;
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, required finish within 1 ms");
    $fatal(1, "watchdog");
  end
  task automatic send_pkt(input int len, input int base, input bit gaps, input int maxb);
    int nb = (len + 3) / 4;
    for (int t = 0; t < nb && t < maxb; t++) begin
      int c = (t == nb - 1) ? len - 4 * t : 4;
      int w = 0;
      bit got = 1'b0;
      while (gaps && $urandom_range(2) == 0) begin @(posedge clk); #1; end
      iv = 1'b1;
      il = (t == nb - 1);
      iuser = 1'(t ^ base);
      for (int i = 0; i < 4; i++) begin
        idata[8*i +: 8] = (i < c) ? 8'(base + 4 * t + i) : 8'hEE;
        ikeep[i] = (i < c);
      end
      while (!got && w < 500) begin
        @(negedge clk);
        got = ir;
        w++;
        @(posedge clk);
        #1;
      end
      iv = 1'b0;
      if (!got) begin
        n_test++; n_fail++;
        $display("FAIL send_timeout: beat %0d of %0d-byte packet got no tready, required within 500 cycles", t, len);
      end
    end
  endtask
  task automatic drain(input int n);
    int w = 0;
    while (obs.size() < n && w < 2000) begin @(posedge clk); #1; w++; end
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic model(input int len, input int base, output bit is_short, output bit is_empty);
    int h = (sel == 2) ? 8 : 6;
    beat_t b;
    logic [63:0] hd = '0;
    is_short = len < h;
    is_empty = len == h && sel == 1;
    for (int i = 0; i < h; i++) hd[8*i +: 8] = 8'(base + i);
    if (len == h && sel != 1) begin
      b = '0; b.l = 1'b1; b.u = 1'(((len - 1) / 4) ^ base); b.h = hd;
      exp.push_back(b);
    end
    if (len > h)
      for (int j = h; j < len; j += 4) begin
        int n = (len - j < 4) ? len - j : 4;
        b = '0; b.h = hd; b.l = (j + n == len); b.u = 1'(((j + n - 1) / 4) ^ base);
        for (int i = 0; i < n; i++) begin b.d[8*i +: 8] = 8'(base + j + i); b.k[i] = 1'b1; end
        exp.push_back(b);
      end
  endtask
  task automatic test_reset;
    sreset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_test++;
    if ({ov, ol, ok, od, ou, oh, sp, ep} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", {ov, ol, ok, od, ou, oh, sp, ep});
    end
    n_test++;
    if (ir !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b, required 0", ir); end
    sreset = 1'b0;
    @(negedge clk);
    n_test++;
    if (ir !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, required 1", ir); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic;
    sel = 0; obs.delete();
    send_pkt(10, 0, 1'b0, 99);
    drain(1);
    n_test++;
    if (obs.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d, required 1", obs.size()); end
    n_test++;
    if (obs[0] !== {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL basic_beat: got %h, required %h", obs[0], {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100});
    end
  endtask
  task automatic test_flush;
    int l0 = low_cnt;
    sel = 0; obs.delete();
    send_pkt(11, 0, 1'b0, 99);
    drain(2);
    n_test++;
    if (obs.size() != 2) begin n_fail++; $display("FAIL flush_count: got %0d, required 2", obs.size()); end
    n_test++;
    if (obs[0] !== {32'h09080706, 4'hF, 1'b0, 1'b0, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL flush_first: got %h, required %h", obs[0], {32'h09080706, 4'hF, 1'b0, 1'b0, 64'h0000050403020100});
    end
    n_test++;
    if (obs[1] !== {32'h0000000A, 4'h1, 1'b1, 1'b0, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL flush_last: got %h, required %h", obs[1], {32'h0000000A, 4'h1, 1'b1, 1'b0, 64'h0000050403020100});
    end
    n_test++;
    if (low_cnt - l0 != 1) begin n_fail++; $display("FAIL flush_ready_low: got %0d cycles, required 1", low_cnt - l0); end
  endtask
  task automatic test_short;
    int s0 = sp_cnt;
    sel = 0; obs.delete();
    send_pkt(4, 0, 1'b0, 99);
    send_pkt(10, 0, 1'b0, 99);
    drain(1);
    n_test++;
    if (sp_cnt - s0 != 1) begin n_fail++; $display("FAIL short_pulse: got %0d, required 1", sp_cnt - s0); end
    n_test++;
    if (obs.size() != 1) begin n_fail++; $display("FAIL short_count: got %0d, required 1", obs.size()); end
    n_test++;
    if (obs[0] !== {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL short_next: got %h, required %h", obs[0], {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100});
    end
  endtask
  task automatic test_empty;
    int e0;
    sel = 0; obs.delete();
    send_pkt(6, 0, 1'b0, 99);
    drain(1);
    n_test++;
    if (obs.size() != 1 || obs[0] !== {32'h0, 4'h0, 1'b1, 1'b1, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL empty_emit: got %0d beats first %h, required 1 beat %h", obs.size(), obs[0], {32'h0, 4'h0, 1'b1, 1'b1, 64'h0000050403020100});
    end
    sel = 1; obs.delete(); e0 = ep_cnt;
    send_pkt(6, 0, 1'b0, 99);
    drain(0);
    n_test++;
    if (obs.size() != 0) begin n_fail++; $display("FAIL empty_drop_count: got %0d, required 0", obs.size()); end
    n_test++;
    if (ep_cnt - e0 != 1) begin n_fail++; $display("FAIL empty_pulse: got %0d, required 1", ep_cnt - e0); end
  endtask
  task automatic test_mid_reset;
    sel = 0; obs.delete();
    send_pkt(20, 8'h40, 1'b0, 3);
    n_test++;
    if (ov !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b, required 1", ov); end
    sreset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_test++;
    if ({ov, ol, ok, od, ou, oh, sp, ep} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h, required 0", {ov, ol, ok, od, ou, oh, sp, ep});
    end
    sreset = 1'b0;
    @(posedge clk);
    #1;
    obs.delete();
    send_pkt(10, 0, 1'b0, 99);
    drain(1);
    n_test++;
    if (obs.size() != 1 || obs[0] !== {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100}) begin
      n_fail++; $display("FAIL mid_reset_next: got %0d beats first %h, required 1 beat %h", obs.size(), obs[0], {32'h09080706, 4'hF, 1'b1, 1'b0, 64'h0000050403020100});
    end
  endtask
  task automatic test_random;
    for (int s = 0; s < 3; s++) begin
      int sp0 = sp_cnt, ep0 = ep_cnt, esp = 0, eep = 0;
      bit bs, be;
      sel = s; obs.delete(); exp.delete(); rnd_rdy = 1'b1;
      for (int p = 0; p < 70; p++) begin
        int len = $urandom_range(40, 1);
        int base = $urandom_range(255);
        model(len, base, bs, be);
        esp += int'(bs);
        eep += int'(be);
        send_pkt(len, base, 1'b1, 99);
      end
      drain(exp.size());
      rnd_rdy = 1'b0;
      n_test++;
      if (obs.size() != exp.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d, required %0d", s, obs.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
        n_test++;
        if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL rand_beat[%0d][%0d]: got %h, required %h", s, i, obs[i], exp[i]); end
      end
      n_test++;
      if (sp_cnt - sp0 != esp || ep_cnt - ep0 != eep) begin
        n_fail++; $display("FAIL rand_pulses[%0d]: got short %0d empty %0d, required %0d %0d", s, sp_cnt - sp0, ep_cnt - ep0, esp, eep);
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_flush;
    test_short;
    test_empty;
    test_mid_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
